// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the block-RAM port-B arbiter.
package mem_arb_pkg;

    typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;

    typedef enum logic {PRI_CPU = 1'b0, PRI_LDR = 1'b1} pri_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [19:0] MMIO_BASE_UPPER = 20'haaaaa;

    function automatic logic out_of_range(input logic [31:0] addr, input logic [19:0] limit);
        return addr[31:12] >= limit;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_rd_owner_pipe.sv
// rd_owner_pipe: RD_LAT-deep valid+owner shift register tracking in-flight reads.
module rd_owner_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   Rst,
    input  logic   push,
    input  owner_t push_owner,
    output logic   vld,
    output owner_t owner
);

    logic [RD_LAT-1:0] vld_p;
    owner_t            owner_p [RD_LAT];

    // Only the valid bits are cleared; owner bits are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (Rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= push;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        owner_p[0] <= push_owner;
        for (int i = 1; i < RD_LAT; i++) begin
            owner_p[i] <= owner_p[i-1];
        end
    end

    assign vld   = vld_p[RD_LAT-1];
    assign owner = owner_p[RD_LAT-1];

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates BRAM port B between the CPU and the UART loader and routes read data back.
// ARB_ROUND_ROBIN_EN selects alternating priority instead of CPU-first with starvation guard.
module shared_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W    = 11,
    parameter int          RD_LAT    = 1,
    parameter int          MAX_WAIT  = 8,
    parameter logic [19:0] MEM_LIMIT = MMIO_BASE_UPPER
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [3:0]        ldr_be,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [31:0]       ldr_rdata,
    output logic              ldr_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    pri_t        pri;
    logic        conflict;
    logic        ldr_wins;
    logic        oor;
    logic        rd_push;
    logic        rd_vld;
    owner_t      rd_owner;
    mem_req_t    sel;
    logic [31:0] cpu_rdata_q;
    logic [31:0] ldr_rdata_q;
    logic [1:0]  unused_addr_lsb;

    assign conflict = cpu_req & ldr_req;
    assign ldr_wins = conflict & (pri == PRI_LDR);
    assign cpu_gnt  = ~Rst & cpu_req & ~ldr_wins;
    assign ldr_gnt  = ~Rst & ldr_req & (~cpu_req | ldr_wins);

    assign sel = ldr_gnt ? '{we: ldr_we, be: ldr_be, addr: ldr_addr, wdata: ldr_wdata}
                         : '{we: cpu_we, be: cpu_be, addr: cpu_addr, wdata: cpu_wdata};
    assign oor = out_of_range(sel.addr, MEM_LIMIT);
    assign unused_addr_lsb = sel.addr[1:0];

    assign cpu_err  = cpu_gnt & oor;
    assign ldr_err  = ldr_gnt & oor;
    assign mem_en   = (cpu_gnt | ldr_gnt) & ~oor;
    assign mem_we   = (mem_en & sel.we) ? sel.be : 4'b0000;
    assign mem_addr = mem_en ? sel.addr[ADDR_W+1:2] : '0;
    assign mem_din  = (mem_en & sel.we) ? sel.wdata : 32'd0;
    // A zero-byte-enable write is still a write: its read data is never returned.
    assign rd_push  = mem_en & ~sel.we;

`ifdef ARB_ROUND_ROBIN_EN
    localparam int unused_max_wait = MAX_WAIT;

    always_ff @(posedge clk) begin
        if (Rst) begin
            pri <= PRI_CPU;
        end else if (conflict) begin
            pri <= (pri == PRI_CPU) ? PRI_LDR : PRI_CPU;
        end
    end
`else
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    // Loader priority is taken exactly when its denied-cycle count saturates.
    always_ff @(posedge clk) begin
        if (Rst) begin
            pri      <= PRI_CPU;
            wait_cnt <= '0;
        end else if (!ldr_req || ldr_gnt) begin
            pri      <= PRI_CPU;
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
            pri      <= (wait_cnt + 1'b1 == WAIT_W'(MAX_WAIT)) ? PRI_LDR : PRI_CPU;
        end
    end
`endif

    rd_owner_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_owner_pipe (
        .clk       (clk),
        .Rst       (Rst),
        .push      (rd_push),
        .push_owner(ldr_gnt ? OWN_LDR : OWN_CPU),
        .vld       (rd_vld),
        .owner     (rd_owner)
    );

    assign cpu_rvalid = ~Rst & rd_vld & (rd_owner == OWN_CPU);
    assign ldr_rvalid = ~Rst & rd_vld & (rd_owner == OWN_LDR);

    always_ff @(posedge clk) begin
        if (Rst) begin
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= mem_dout;
            if (ldr_rvalid) ldr_rdata_q <= mem_dout;
        end
    end

    assign cpu_rdata = Rst ? 32'd0 : (cpu_rvalid ? mem_dout : cpu_rdata_q);
    assign ldr_rdata = Rst ? 32'd0 : (ldr_rvalid ? mem_dout : ldr_rdata_q);

endmodule
